// File: rtl/aes_uart_tx_scheduler_if.sv
// Block-request and UART byte handshake bundle for the AES-over-UART scheduler.
// The master side is the scheduler; the slave side is the producers plus UART.
interface aes_uart_tx_scheduler_if #(
    parameter int NUM_BYTES = 16
);
    logic                   req0;
    logic [8*NUM_BYTES-1:0] blk0;
    logic                   gnt0;
    logic                   req1;
    logic [8*NUM_BYTES-1:0] blk1;
    logic                   gnt1;
    logic                   tx_start;
    logic [7:0]             tx_data;
    logic                   tx_busy;
    logic                   busy;
    logic                   owner;
    logic                   done;

    modport master (
        input  req0, blk0, req1, blk1, tx_busy,
        output gnt0, gnt1, tx_start, tx_data, busy, owner, done
    );

    modport slave (
        output req0, blk0, req1, blk1, tx_busy,
        input  gnt0, gnt1, tx_start, tx_data, busy, owner, done
    );
endinterface

// File: rtl/aes_uart_tx_scheduler.sv
// Round-robin grant of two 128-bit block producers onto a byte-wide UART TX,
// sequencing each captured block MSB byte first with a start/busy handshake.
module aes_uart_tx_scheduler #(
    parameter int NUM_BYTES  = 16,
    parameter int GAP_CYCLES = 0
) (
    input logic                     clk,
    input logic                     reset_n,
    aes_uart_tx_scheduler_if.master bus
);
    localparam int W  = 8 * NUM_BYTES;
    localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GUARD,
        WAIT,
        GAP
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [7:0]    gap_cnt, gap_nxt;
    logic [W-1:0]  sr, sr_nxt;
    logic          ptr, ptr_nxt;
    logic          owner, owner_nxt;
    logic          gnt0, gnt0_nxt;
    logic          gnt1, gnt1_nxt;
    logic          start, start_nxt;
    logic [7:0]    data, data_nxt;
    logic          done, done_nxt;
    logic          pick;

    // ptr=0 favours req0 on contention
    assign pick = (bus.req0 && bus.req1) ? ptr : bus.req1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            gap_cnt <= '0;
            sr      <= '0;
            ptr     <= 1'b0;
            owner   <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            start   <= 1'b0;
            data    <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            gap_cnt <= gap_nxt;
            sr      <= sr_nxt;
            ptr     <= ptr_nxt;
            owner   <= owner_nxt;
            gnt0    <= gnt0_nxt;
            gnt1    <= gnt1_nxt;
            start   <= start_nxt;
            data    <= data_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gap_nxt   = gap_cnt;
        sr_nxt    = sr;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        data_nxt  = data;
        gnt0_nxt  = 1'b0;
        gnt1_nxt  = 1'b0;
        start_nxt = 1'b0;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    gnt0_nxt  = ~pick;
                    gnt1_nxt  = pick;
                    sr_nxt    = pick ? bus.blk1 : bus.blk0;
                    owner_nxt = pick;
                    ptr_nxt   = ~pick;
                    cnt_nxt   = '0;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.tx_busy) begin
                    start_nxt = 1'b1;
                    data_nxt  = sr[W-1 -: 8];
                    sr_nxt    = sr << 8;
                    state_nxt = GUARD;
                end
            end
            // UART gets one cycle to raise tx_busy before it is trusted
            GUARD: state_nxt = WAIT;
            WAIT: begin
                if (!bus.tx_busy) begin
                    if (cnt == LAST) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt   = cnt + CW'(1);
                        gap_nxt   = '0;
                        state_nxt = (GAP_CYCLES > 0) ? GAP : ISSUE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = ISSUE;
                end else begin
                    gap_nxt = gap_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.gnt0     = gnt0;
    assign bus.gnt1     = gnt1;
    assign bus.tx_start = start;
    assign bus.tx_data  = data;
    assign bus.busy     = (state != IDLE);
    assign bus.owner    = owner;
    assign bus.done     = done;
endmodule

// File: doc/aes_uart_tx_scheduler.md
Name: aes_uart_tx_scheduler

Overview:
- Sits between the two 128-bit block producers and the byte-wide UART transmitter in the AES-over-UART link.
- Requester 0 is the AES ciphertext output; requester 1 is the echo/status path.
- Grants one requester at a time, round-robin, and captures its block.
- Sequences the block out MSB byte first with a start/busy handshake to the UART TX, so no byte is lost to backpressure.

Parameters:
- NUM_BYTES, 16: bytes per block. Block width is 8*NUM_BYTES. The byte counter is wide enough for NUM_BYTES-1.
- GAP_CYCLES, 0: idle cycles inserted after each completed byte before the next tx_start. Range 0..255.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 has a block; held until gnt0.
- blk0  in  8*NUM_BYTES  requester 0 block; stable while req0 is high.
- gnt0  out  1  one-cycle pulse; blk0 captured this cycle.
- req1  in  1  requester 1 request; same rules as req0.
- blk1  in  8*NUM_BYTES  requester 1 block.
- gnt1  out  1  one-cycle pulse; blk1 captured.
- tx_start  out  1  one-cycle pulse; UART latches tx_data.
- tx_data  out  8  byte to transmit; valid whenever tx_start=1.
- tx_busy  in  1  UART is transmitting; rises the cycle after an accepted tx_start at the latest.
- busy  out  1  a block is being sequenced (any state other than IDLE).
- owner  out  1  requester of the current or last block.
- done  out  1  one-cycle pulse when the last byte of a block has completed.

Behaviour:
- Reset values: gnt0=0, gnt1=0, tx_start=0, tx_data=0, busy=0, owner=0, done=0. State is IDLE, byte counter 0, shift register 0, priority pointer favours req0.
- States: IDLE, ISSUE, GUARD, WAIT, GAP.
- IDLE, arbitration:
  - Only req0: grant 0. Only req1: grant 1.
  - Both: grant the requester the priority pointer favours. The pointer then favours the other requester.
  - Grant cycle: registered gnt pulse in the same cycle as block capture into the shift register; owner updated; counter=0; next state ISSUE.
  - No req: stay in IDLE.
- ISSUE:
  - If tx_busy=0: tx_start=1 and tx_data = shift_reg top byte. Shift left by 8 and go to GUARD.
  - If tx_busy=1: hold, tx_start=0.
- GUARD: one cycle; tx_busy is ignored so the UART has time to raise it. Next state WAIT.
- WAIT: remain while tx_busy=1. On tx_busy=0:
  - If counter == NUM_BYTES-1: done=1 pulse, go to IDLE. A new grant is possible on the following cycle.
  - Else: counter+1, then GAP if GAP_CYCLES>0, otherwise ISSUE.
- GAP: count GAP_CYCLES cycles, then ISSUE.
- Latency:
  - req seen in IDLE → gnt in the next cycle.
  - gnt → first tx_start one cycle later, if tx_busy=0.
- tx_start never asserts twice without an intervening tx_busy=0 observed in WAIT.
- Requests:
  - Not sampled outside IDLE; they stay pending. No grant is issued while busy=1.
  - req dropped before gnt: no capture, nothing sent.
- Reset mid-block: immediate return to reset values; the partial block is abandoned with no done pulse. The requester must re-request.
- tx_data holds its last value between tx_start pulses.

Test Plan:
- Single block: req0=1, blk0=0x00112233445566778899AABBCCDDEEFF, UART model busy 3 cycles per byte → one gnt0 pulse, owner=0. 16 tx_start pulses with tx_data 00,11,22,…,FF in order. One done pulse after the last busy falls; busy=0 afterwards.
- Contention: req0 and req1 both high after reset → req0 served first, then req1 (gnt1 the cycle after returning to IDLE). Both re-raised → next order is req0 again, since the pointer alternates.
- Backpressure: tx_busy forced high while in ISSUE for 50 cycles → tx_start stays 0. Release → exactly one tx_start, byte sequence unchanged.
- Gap: GAP_CYCLES=2, UART busy 1 cycle → spacing between tx_start pulses = 1 (GUARD) + 1 busy + 1 (WAIT exit) + 2 gap.
- Reset mid-block: assert reset_n=0 after 5 bytes → all outputs 0 immediately, no done. Re-request → transmission restarts from byte 00.
- Withdrawn request: req1 pulsed while busy and dropped before block end → no gnt1 and no extra bytes.
